uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// The line is synchronised, sampled mid-bit and decoded by a single FSM.
// Received data and error flags are presented together with a one-cycle
// rx_valid pulse.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // BIT_CYCLES must be at least 4 so that HALF - 1 is a valid count.
    localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int unsigned HALF       = BIT_CYCLES / 2;
    localparam int unsigned CW         = $clog2(BIT_CYCLES);

    localparam logic [CW-1:0] BitLast  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HalfLast = CW'(HALF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_mis;
    logic          rx_meta;
    logic          rx_s;

    // Two-flop synchroniser, reset to the idle-high line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: bit timing, shift register, parity tracking and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_mis    <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                StStart: begin
                    if (cnt == HalfLast) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= StData;
                            bit_idx <= '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch, not a start bit
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StData: begin
                    if (cnt == BitLast) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= StParity;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StParity: begin
                    if (cnt == BitLast) begin
                        cnt     <= '0;
                        par_mis <= (^shift) ^ PARITY_ODD ^ rx_s;
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StStop: begin
                    if (cnt == BitLast) begin
                        cnt        <= '0;
                        rx_data    <= shift;
                        rx_valid   <= 1'b1;
                        parity_err <= par_mis;
                        frame_err  <= ~rx_s;
                        if (rx_s) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            state <= StBreak;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                StBreak: begin
                    // Wait for the line to return high so a held-low line yields one frame only
                    if (rx_s) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
